// File: rtl/tx_shift_slave_pkg.sv
// Shared definitions for the serial word source and its receiver FSM.
// Both ends must agree on the word width and the holding-register encodings.
package tx_shift_slave_pkg;

    // Default word width exponent: the word is 2^DATA_WIDTH_BASE bits wide.
    localparam int unsigned DATA_WIDTH_BASE_DEF = 5;

    // Holding-register occupancy.
    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_t;

    // Word width for a given width exponent.
    function automatic int unsigned word_width(input int unsigned base);
        return 32'(1) << base;
    endfunction

endpackage

// File: rtl/tx_shift_slave_sck_edge_det.sv
// Rising-edge detector for the receiver's serial clock.
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-low reset
//   sck_rx     - serial clock level, already in the clk domain
//   sck_rise_c - combinational one-cycle pulse on a 0->1 transition of sck_rx
module tx_shift_slave_sck_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sck_rx,
    output logic sck_rise_c
);

    logic sck_q;

    // One-cycle delayed copy of sck_rx.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_q <= 1'b0;
        end else begin
            sck_q <= sck_rx;
        end
    end

    // A level held high produces only this single pulse.
    assign sck_rise_c = sck_rx & ~sck_q;

endmodule

// File: rtl/tx_shift_slave.sv
// Parallel-in/serial-out word source feeding the serial receiver FSM.
// A producer hands words over through a one-entry holding register; a
// latch-qualified sck_rx edge moves the held word into the shifter, and each
// following sck_rx edge presents the next bit, LSB first.
// Ports:
//   clk, rst    - system clock; asynchronous active-low reset
//   sck_rx      - serial clock level from the receiver
//   latch_flag  - qualifies an sck_rx edge as a load instead of a shift
//   data_rx     - serial bit presented to the receiver
//   tx_data     - parallel word from the producer
//   tx_valid    - tx_data is valid
//   tx_ready    - holding register empty; accept on tx_valid && tx_ready
//   busy        - shifter holds undelivered bits
//   word_sent   - one-cycle pulse when the last bit has been consumed
//   underrun    - one-cycle pulse when a load finds the holding register empty
module tx_shift_slave
    import tx_shift_slave_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_BASE = DATA_WIDTH_BASE_DEF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                sck_rx,
    input  logic                                latch_flag,
    output logic                                data_rx,
    input  logic [(1 << DATA_WIDTH_BASE)-1:0]   tx_data,
    input  logic                                tx_valid,
    output logic                                tx_ready,
    output logic                                busy,
    output logic                                word_sent,
    output logic                                underrun
);

    localparam int unsigned W = word_width(DATA_WIDTH_BASE);
    localparam logic [DATA_WIDTH_BASE-1:0] LAST_IDX = DATA_WIDTH_BASE'(W - 1);

    hold_state_t                state;
    logic [W-1:0]               holding;
    logic [W-1:0]               shifter;
    logic [DATA_WIDTH_BASE-1:0] bit_idx;

    logic sck_rise_c;
    logic load_c;
    logic shift_c;
    logic accept_c;

    tx_shift_slave_sck_edge_det u_sck_edge_det (
        .clk        (clk),
        .rst        (rst),
        .sck_rx     (sck_rx),
        .sck_rise_c (sck_rise_c)
    );

    // Edge classification: loads and shifts only happen on an sck_rx rise.
    assign load_c   = sck_rise_c &  latch_flag;
    assign shift_c  = sck_rise_c & ~latch_flag;
    assign accept_c = tx_valid & tx_ready;

    // Holding-register FSM; tx_ready is kept as a flop mirroring HOLD_EMPTY.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= HOLD_EMPTY;
            holding  <= '0;
            tx_ready <= 1'b1;
        end else begin
            case (state)
                HOLD_EMPTY: begin
                    // A same-cycle load found us empty; the word still lands here.
                    if (accept_c) begin
                        holding  <= tx_data;
                        state    <= HOLD_FULL;
                        tx_ready <= 1'b0;
                    end
                end
                HOLD_FULL: begin
                    if (load_c) begin
                        state    <= HOLD_EMPTY;
                        tx_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= HOLD_EMPTY;
                    tx_ready <= 1'b1;
                end
            endcase
        end
    end

    // Shifter, bit counter and serial output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shifter   <= '0;
            bit_idx   <= '0;
            busy      <= 1'b0;
            data_rx   <= 1'b0;
            word_sent <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            word_sent <= 1'b0;
            underrun  <= 1'b0;
            if (load_c) begin
                // A load while busy simply restarts; the aborted word never reports.
                bit_idx <= '0;
                busy    <= 1'b1;
                if (state == HOLD_FULL) begin
                    shifter <= holding;
                    data_rx <= holding[0];
                end else begin
                    shifter  <= '0;
                    data_rx  <= 1'b0;
                    underrun <= 1'b1;
                end
            end else if (shift_c && busy) begin
                shifter <= {1'b0, shifter[W-1:1]};
                bit_idx <= bit_idx + DATA_WIDTH_BASE'(1);
                if (bit_idx == LAST_IDX) begin
                    // Final shift consumes the last bit; the line idles low.
                    busy      <= 1'b0;
                    word_sent <= 1'b1;
                    data_rx   <= 1'b0;
                end else begin
                    data_rx <= shifter[1];
                end
            end
        end
    end

endmodule

// File: tb/tb_tx_shift_slave.sv
// Scoreboard bench for tx_shift_slave: stimulus pushes the expected output
// state for every sck_rx rising edge; the monitor pops and compares on the
// falling edge after the clock edge that processed it.
module tb_tx_shift_slave;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst;
    logic         sck_rx;
    logic         latch_flag;
    logic         data_rx;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         busy;
    logic         word_sent;
    logic         underrun;

    typedef struct packed {
        logic data;
        logic bsy;
        logic ws;
        logic ur;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;
    logic sck_h1   = 1'b0;
    logic sck_h2   = 1'b0;

    tx_shift_slave dut (
        .clk        (clk),
        .rst        (rst),
        .sck_rx     (sck_rx),
        .latch_flag (latch_flag),
        .data_rx    (data_rx),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .word_sent  (word_sent),
        .underrun   (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic d, input logic b, input logic ws, input logic ur);
        exp_t e;
        e.data = d;
        e.bsy  = b;
        e.ws   = ws;
        e.ur   = ur;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One sck_rx pulse held high for 'hi' cycles, then one low cycle.
    task automatic pulse(input logic latch, input int hi);
        latch_flag = latch;
        sck_rx     = 1'b1;
        repeat (hi) tick();
        sck_rx     = 1'b0;
        latch_flag = 1'b0;
        tick();
    endtask

    task automatic accept(input logic [W-1:0] w);
        int n = 0;
        while (!tx_ready && n < 100) begin
            tick();
            n++;
        end
        if (!tx_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: tx_ready got 0 expected 1 within 100 cycles");
        end
        tx_data  = w;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check("tx_ready_after_accept", 32'(tx_ready), 32'(0));
    endtask

    // Load a word known to be held: bit 0 appears with busy set.
    task automatic load_word(input logic [W-1:0] w);
        push_exp(w[0], 1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1);
    endtask

    // Shifts number 'from'..'to'; shift k presents bit k, shift W ends the word.
    task automatic shifts(input logic [W-1:0] w, input int from, input int to);
        for (int k = from; k <= to; k++) begin
            if (k < int'(W)) push_exp(w[k], 1'b1, 1'b0, 1'b0);
            else             push_exp(1'b0, 1'b0, 1'b1, 1'b0);
            pulse(1'b0, 1);
        end
    endtask

    // Monitor: an sck_rx rise seen at the previous negedge was processed by
    // the posedge just passed, so its response is visible now.
    always @(negedge clk) begin
        exp_t e;
        if (!rst || !mon_en) begin
            sck_h1 = 1'b0;
            sck_h2 = 1'b0;
        end else begin
            if (sck_h1 && !sck_h2) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got an sck edge expected none at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("data_rx",   32'(data_rx),   32'(e.data));
                    check("busy",      32'(busy),      32'(e.bsy));
                    check("word_sent", 32'(word_sent), 32'(e.ws));
                    check("underrun",  32'(underrun),  32'(e.ur));
                end
            end else begin
                check("idle_pulses", {30'd0, word_sent, underrun}, 32'd0);
            end
            sck_h2 = sck_h1;
            sck_h1 = sck_rx;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b0;
        sck_rx     = 1'b0;
        latch_flag = 1'b0;
        tx_data    = '0;
        tx_valid   = 1'b0;
        repeat (3) tick();

        // Reset values.
        check("rst_data_rx",   32'(data_rx),   32'(0));
        check("rst_tx_ready",  32'(tx_ready),  32'(1));
        check("rst_busy",      32'(busy),      32'(0));
        check("rst_word_sent", 32'(word_sent), 32'(0));
        check("rst_underrun",  32'(underrun),  32'(0));
        rst = 1'b1;
        tick();
        mon_en = 1'b1;
        tick();

        // Full word: latched pulse plus 32 shifts.
        accept(32'hA5A5_0F0F);
        load_word(32'hA5A5_0F0F);
        check("tx_ready_after_load", 32'(tx_ready), 32'(1));
        shifts(32'hA5A5_0F0F, 1, 32);
        check("full_busy_end", 32'(busy), 32'(0));
        check("full_data_end", 32'(data_rx), 32'(0));

        // Back-to-back with the second word accepted mid-shift.
        accept(32'h1234_5678);
        load_word(32'h1234_5678);
        shifts(32'h1234_5678, 1, 5);
        accept(32'hDEAD_BEEF);
        shifts(32'h1234_5678, 6, 32);
        load_word(32'hDEAD_BEEF);
        shifts(32'hDEAD_BEEF, 1, 32);

        // Underrun: load with holding empty gives zeros and a full frame.
        push_exp(1'b0, 1'b1, 1'b0, 1'b1);
        pulse(1'b1, 1);
        shifts(32'h0000_0000, 1, 32);

        // Abort: reload after 10 shifts; the first word never reports.
        accept(32'hFFFF_FFFF);
        load_word(32'hFFFF_FFFF);
        shifts(32'hFFFF_FFFF, 1, 10);
        accept(32'h0000_0001);
        load_word(32'h0000_0001);
        shifts(32'h0000_0001, 1, 32);

        // Edge robustness: stuck-high sck shifts once; latch toggling alone does nothing.
        accept(32'h0000_00F0);
        load_word(32'h0000_00F0);
        shifts(32'h0000_00F0, 1, 3);
        push_exp(1'b1, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 5);
        for (int i = 0; i < 6; i++) begin
            latch_flag = ~latch_flag;
            tick();
        end
        latch_flag = 1'b0;
        tick();
        check("edge_busy_hold", 32'(busy), 32'(1));
        check("edge_data_hold", 32'(data_rx), 32'(1));
        shifts(32'h0000_00F0, 5, 32);

        // Reset mid-word with a second word waiting in holding.
        accept(32'hC3C3_C3C3);
        load_word(32'hC3C3_C3C3);
        shifts(32'hC3C3_C3C3, 1, 7);
        accept(32'h55AA_55AA);
        repeat (2) tick();
        check("pre_rst_busy", 32'(busy), 32'(1));
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_data_rx",   32'(data_rx),   32'(0));
        check("mid_rst_busy",      32'(busy),      32'(0));
        check("mid_rst_tx_ready",  32'(tx_ready),  32'(1));
        check("mid_rst_word_sent", 32'(word_sent), 32'(0));
        check("mid_rst_underrun",  32'(underrun),  32'(0));
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_tx_ready", 32'(tx_ready), 32'(1));
        // Shift while idle is ignored; a load finds the held word gone.
        push_exp(1'b0, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1);
        push_exp(1'b0, 1'b1, 1'b0, 1'b1);
        pulse(1'b1, 1);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
